// File: rtl/pwm_duty_generator.sv
// Prescaled PWM generator with a double-buffered duty word applied only at period boundaries.
// Optional macro PWM_SLEW_LIMIT_EN limits each duty update to MAX_STEP counts.
module pwm_duty_generator #(
  parameter int unsigned DUTY_W   = 10,
  parameter int unsigned PERIOD   = 1023,
  parameter int unsigned PRESCALE = 49,
  parameter int unsigned MAX_STEP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic [DUTY_W-1:0] PWMinput,
  input  logic              InputValid,
  output logic              PWMout,
  output logic              PeriodStart,
  output logic [DUTY_W-1:0] DutyActive
);

`ifdef PWM_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam int unsigned PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);
  localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(PRESCALE);
  // A step of PERIOD can never bind, so the unlimited build reaches the target in one update.
  localparam int unsigned STEP_LIMIT = (SLEW_EN && (MAX_STEP < PERIOD)) ? MAX_STEP : PERIOD;
  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP_LIMIT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [DUTY_W-1:0] cnt, cnt_n;
  logic [PS_W-1:0]   prescaler, prescaler_n;
  logic [DUTY_W-1:0] pending, pending_n;
  logic              pend_flag, pend_flag_n;
  logic [DUTY_W-1:0] duty_n, clamped, target;
  logic              want, tick, start, wrap, pwm_n;

  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (tgt > cur)
      return ((tgt - cur) > STEP_V) ? cur + STEP_V : tgt;
    else
      return ((cur - tgt) > STEP_V) ? cur - STEP_V : tgt;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    clamped     = (PWMinput > PERIOD_V) ? PERIOD_V : PWMinput;
    target      = InputValid ? clamped : pending;
    want        = InputValid | pend_flag;
    tick        = (prescaler == PS_MAX);
    start       = (state == IDLE) && Enable;
    wrap        = (state == RUN) && Enable && tick && (cnt == LAST_CNT);
    state_n     = state;
    cnt_n       = cnt;
    prescaler_n = prescaler;
    duty_n      = DutyActive;
    pending_n   = target;
    pend_flag_n = want;

    if (!Enable) begin
      state_n     = IDLE;
      cnt_n       = '0;
      prescaler_n = '0;
    end else if (start) begin
      state_n     = RUN;
      cnt_n       = '0;
      prescaler_n = '0;
      duty_n      = step_toward(DutyActive, target);
      pend_flag_n = (duty_n != target);
    end else if (tick) begin
      prescaler_n = '0;
      if (wrap) begin
        cnt_n = '0;
        // A strobe on the wrap cycle feeds straight into the new period.
        if (want) begin
          duty_n      = step_toward(DutyActive, target);
          pend_flag_n = (duty_n != target);
        end
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      prescaler_n = prescaler + 1'b1;
    end

    // Compare against next-state values so the pin lines up with the counter it reflects.
    pwm_n = (state_n == RUN) && (cnt_n < duty_n);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      prescaler   <= '0;
      pending     <= '0;
      pend_flag   <= 1'b0;
      DutyActive  <= '0;
      PWMout      <= 1'b0;
      PeriodStart <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      prescaler   <= prescaler_n;
      pending     <= pending_n;
      pend_flag   <= pend_flag_n;
      DutyActive  <= duty_n;
      PWMout      <= pwm_n;
      PeriodStart <= start | wrap;
    end
  end

endmodule
